// File: rtl/product_1.sv
// product_1: unsigned 8x8->16 multiplier (partial products, carry-save tree, ripple CPA) with an optional registered copy
//   clk, rst_n            : clock, asynchronous active-low reset
//   mult1_A, mult1_B      : unsigned operands
//   mult1_valid_in        : capture the current product on the next rising edge
//   mult_out_1            : combinational product
//   mult_out_1_q          : registered product, cleared by reset
//   mult1_valid_out       : mult_out_1_q was loaded on the last edge
module product_1_csa (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  output logic [15:0] s_o,
  output logic [15:0] c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  // The carry out of bit 15 is dropped: the true product always fits in 16 bits.
  assign c_o = {(a_i[14:0] & b_i[14:0]) | (a_i[14:0] & c_i[14:0]) | (b_i[14:0] & c_i[14:0]), 1'b0};
endmodule

module product_1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mult1_A,
  input  logic [7:0]  mult1_B,
  input  logic        mult1_valid_in,
  output logic [15:0] mult_out_1,
  output logic [15:0] mult_out_1_q,
  output logic        mult1_valid_out
);
  logic [15:0] pp [0:7];
  logic [15:0] s1a, c1a, s1b, c1b, s2a, c2a, s2b, c2b, s3, c3, sum_v, car_v;
  logic [15:0] cy;
  logic [15:0] mult_out_1_d;
  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = {8'h00, mult1_A & {8{mult1_B[i]}}} << i;
  end
  // Eight rows reduce 8 -> 6 -> 4 -> 3 -> 2 through full-adder rows.
  product_1_csa u_l1a (.a_i(pp[0]), .b_i(pp[1]), .c_i(pp[2]), .s_o(s1a), .c_o(c1a));
  product_1_csa u_l1b (.a_i(pp[3]), .b_i(pp[4]), .c_i(pp[5]), .s_o(s1b), .c_o(c1b));
  product_1_csa u_l2a (.a_i(s1a), .b_i(c1a), .c_i(s1b), .s_o(s2a), .c_o(c2a));
  product_1_csa u_l2b (.a_i(c1b), .b_i(pp[6]), .c_i(pp[7]), .s_o(s2b), .c_o(c2b));
  product_1_csa u_l3  (.a_i(s2a), .b_i(c2a), .c_i(s2b), .s_o(s3), .c_o(c3));
  product_1_csa u_l4  (.a_i(s3), .b_i(c3), .c_i(c2b), .s_o(sum_v), .c_o(car_v));
  assign cy[0] = 1'b0;
  for (genvar k = 0; k < 15; k++) begin : g_cy
    assign cy[k+1] = (sum_v[k] & car_v[k]) | (sum_v[k] & cy[k]) | (car_v[k] & cy[k]);
  end
  assign mult_out_1 = sum_v ^ car_v ^ cy;
  assign mult_out_1_d = mult1_valid_in ? mult_out_1 : mult_out_1_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mult_out_1_q    <= 16'h0000;
      mult1_valid_out <= 1'b0;
    end else begin
      mult_out_1_q    <= mult_out_1_d;
      mult1_valid_out <= mult1_valid_in;
    end
endmodule

// File: tb/tb_product_1.sv
// tb_product_1: self-checking bench for product_1 against an arithmetic reference
module tb_product_1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  mult1_A = 8'd0;
  logic [7:0]  mult1_B = 8'd0;
  logic        mult1_valid_in = 1'b0;
  logic [15:0] mult_out_1;
  logic [15:0] mult_out_1_q;
  logic        mult1_valid_out;
  int checks = 0;
  int failures = 0;

  product_1 dut (
    .clk(clk), .rst_n(rst_n), .mult1_A(mult1_A), .mult1_B(mult1_B),
    .mult1_valid_in(mult1_valid_in), .mult_out_1(mult_out_1),
    .mult_out_1_q(mult_out_1_q), .mult1_valid_out(mult1_valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input int a, input int b);
    return 16'(a * b);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag, input int a, input int b);
    mult1_A = 8'(a);
    mult1_B = 8'(b);
    #1;
    chk(tag, mult_out_1, ref_prod(a, b));
  endtask

  task automatic chk_reg(input string tag, input int q, input int v);
    chk({tag, "_q"}, mult_out_1_q, 16'(q));
    chk({tag, "_valid"}, {15'd0, mult1_valid_out}, 16'(v));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_reg("reset", 0, 0);
    comb("comb_in_reset", 9, 11);
    @(negedge clk) rst_n = 1'b1;
    comb("zero_zero", 0, 0);
    comb("zero_255", 0, 255);
    comb("one_one", 1, 1);
    comb("one_200", 1, 200);
    comb("max_max", 255, 255);
    comb("shift_128_2", 128, 2);
    comb("mid_100_50", 100, 50);
    for (int i = 0; i < 8; i++) comb("pow2_shift", 1 << i, 8'hA5);
    for (int i = 0; i < 20; i++) comb("random", $urandom_range(0, 255), $urandom_range(0, 255));
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++) begin
        mult1_A = 8'(a);
        mult1_B = 8'(b);
        #1;
        checks++;
        assert (mult_out_1 === ref_prod(a, b)) else begin
          failures++;
          $error("FAIL sweep a=%0d b=%0d observed=%0d expected=%0d", a, b, mult_out_1, ref_prod(a, b));
        end
      end
    @(negedge clk);
    mult1_A = 8'd12; mult1_B = 8'd13; mult1_valid_in = 1'b1;
    @(posedge clk) #1 chk_reg("pipe0", 156, 1);
    mult1_A = 8'd255; mult1_B = 8'd2;
    @(posedge clk) #1 chk_reg("pipe1", 510, 1);
    mult1_valid_in = 1'b0; mult1_A = 8'd7; mult1_B = 8'd9;
    @(posedge clk) #1 chk_reg("hold", 510, 0);
    mult1_valid_in = 1'b1; mult1_A = 8'd255; mult1_B = 8'd2;
    @(posedge clk) #1 chk_reg("reload", 510, 1);
    mult1_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reg("async_reset", 0, 0);
    comb("comb_during_reset", 3, 5);
    mult1_valid_in = 1'b1; mult1_A = 8'd40; mult1_B = 8'd40;
    @(posedge clk) #1 chk_reg("reset_holds", 0, 0);
    @(negedge clk) rst_n = 1'b1;
    mult1_A = 8'd12; mult1_B = 8'd13;
    @(posedge clk) #1 chk_reg("first_after_reset", 156, 1);
    mult1_valid_in = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/product_1.md
Name: product_1

Overview:
- Unsigned 8x8 -> 16-bit multiplier slice for the execution unit.
- Serves as one of the sub-products that the wider vector multiplier combines.
- Provides a purely combinational product output plus an optional one-cycle registered copy with a valid flag, for pipelined consumers.
- Built structurally: partial-product array, carry-save reduction tree, final carry-propagate adder.

Parameters:
- None. Widths are fixed: 8-bit operands, 16-bit product.

Ports:
- clk  input  1  system clock; rising edge active
- rst_n  input  1  asynchronous, active-low reset
- mult1_A  input  8  unsigned multiplicand
- mult1_B  input  8  unsigned multiplier
- mult1_valid_in  input  1  operands on mult1_A/mult1_B are to be captured this cycle
- mult_out_1  output  16  combinational product, mult1_A * mult1_B
- mult_out_1_q  output  16  registered product
- mult1_valid_out  output  1  mult_out_1_q holds a fresh product

Behaviour:
- Arithmetic:
  - mult_out_1 = mult1_A * mult1_B, both operands unsigned, full 16-bit result.
  - No truncation and no overflow possible; maximum is 255*255 = 65025 = 0xFE01.
- Combinational path:
  - mult_out_1 depends only on mult1_A and mult1_B, with zero clock latency.
  - It is independent of clk and rst_n, and stays valid during reset.
  - It must settle well within 1 ns in RTL simulation, i.e. no delays inside the DUT.
- Structure:
  - 8 partial-product rows, pp[i][j] = A[j] & B[i], with row i weighted by 2^i.
  - Rows reduced with half and full adders in carry-save form (Wallace or Dadda) to two 16-bit vectors.
  - Final ripple or other carry-propagate adder produces mult_out_1.
  - The behavioural "*" operator is not used in the datapath.
- Registered path:
  - On posedge clk with mult1_valid_in=1: mult_out_1_q <= mult_out_1 and mult1_valid_out <= 1.
  - On posedge clk with mult1_valid_in=0: mult_out_1_q holds its value and mult1_valid_out <= 0.
  - Latency is 1 cycle; one new operation can be accepted every cycle.
- Reset:
  - rst_n low forces mult_out_1_q = 16'h0000 and mult1_valid_out = 0 immediately, without waiting for a clock edge.
  - Deasserting reset mid-stream discards any operation in flight. The first capture happens on the first posedge with rst_n=1 and mult1_valid_in=1.
- Boundaries:
  - A=0 or B=0 gives 0.
  - A=1 gives B.
  - A power of two gives a shifted B.
  - X/Z operands are not defined; the bench drives only known values.

Test Plan:
- Zero/identity: (0,0) -> 0x0000; (0,255) -> 0x0000; (1,1) -> 0x0001; (1,200) -> 200 (0x00C8). Check mult_out_1 1 ns after each input change.
- Extremes and shifts: (255,255) -> 65025 (0xFE01); (128,2) -> 256 (0x0100); (100,50) -> 5000 (0x1388).
- Random: at least 10 random pairs in 0..255, each compared against a TB-computed A*B. Then an exhaustive sweep of all 65536 pairs with zero mismatches.
- Pipeline:
  - Cycle 0: valid_in=1 with (12,13); cycle 1: valid_in=1 with (255,2).
  - Required: mult_out_1_q = 156 with valid_out=1 after the first edge, then 510 with valid_out=1.
  - Then drive valid_in=0: required q holds 510 and valid_out=0.
- Async reset: with q=510 and valid_out=1, pulse rst_n low between clock edges.
  - Required: q=0 and valid_out=0 before the next edge.
  - mult_out_1 still tracks the inputs while rst_n is low.
